// File: rtl/icon_scheduler_pkg.sv
// ============================================================================
// icon_pkg: shared constants, FSM encoding and sprite position record.
// Rev 1.0
// ============================================================================
`default_nettype none

package icon_pkg;

    localparam int ICON_WIDTH  = 15;
    localparam int ICON_HEIGHT = 15;
    localparam int ICON_SIZE   = ICON_WIDTH * ICON_HEIGHT;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } icon_pos_t;

endpackage

`default_nettype wire

// File: rtl/icon_scheduler_if.sv
// ============================================================================
// icon_scheduler_if: sprite position update handshake (valid/ready).
// Rev 1.0
// ============================================================================
`default_nettype none

interface icon_scheduler_if #(
    parameter int ID_W = 2
) ();

    logic            upd_valid;
    logic            upd_ready;
    logic [ID_W-1:0] upd_id;
    logic [9:0]      upd_x;
    logic [9:0]      upd_y;
    logic            upd_en;

    modport master (
        output upd_valid, upd_id, upd_x, upd_y, upd_en,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_id, upd_x, upd_y, upd_en,
        output upd_ready
    );

endinterface

`default_nettype wire

// File: rtl/icon_scheduler_hit_test.sv
// ============================================================================
// icon_hit_test: coverage test of one sprite against the scan position.
// Rev 1.0
// ============================================================================
`default_nettype none

module icon_hit_test #(
    parameter int ICON_WIDTH  = icon_pkg::ICON_WIDTH,
    parameter int ICON_HEIGHT = icon_pkg::ICON_HEIGHT,
    parameter int ADDR_W      = 10
) (
    input  icon_pkg::icon_pos_t pos,
    input  logic [9:0]          vert,
    input  logic [9:0]          horz,
    output logic                hit,
    output logic [ADDR_W-1:0]   ofs
);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0]  dx;
    logic [9:0]  dy;

    // 11-bit end bounds keep sprites near column/row 1023 from wrapping to 0
    assign x_end = {1'b0, pos.x} + 11'(ICON_WIDTH);
    assign y_end = {1'b0, pos.y} + 11'(ICON_HEIGHT);
    assign dx    = horz - pos.x;
    assign dy    = vert - pos.y;

    assign hit = pos.en
              && (vert >= pos.y) && ({1'b0, vert} < y_end)
              && (horz >= pos.x) && ({1'b0, horz} < x_end);

    assign ofs = ADDR_W'(dy) * ADDR_W'(ICON_WIDTH) + ADDR_W'(dx);

endmodule

`default_nettype wire

// File: rtl/icon_scheduler.sv
// ============================================================================
// icon_scheduler: per-frame atomic sprite positions, priority pick, ROM addressing.
// Rev 1.0
// ============================================================================
`default_nettype none

module icon_scheduler #(
    parameter int NUM_ICONS   = 4,
    parameter int ICON_WIDTH  = icon_pkg::ICON_WIDTH,
    parameter int ICON_HEIGHT = icon_pkg::ICON_HEIGHT,
    parameter int ICON_SIZE   = ICON_WIDTH * ICON_HEIGHT,
    parameter int BLANK       = NUM_ICONS * ICON_SIZE,
    parameter int ADDR_W      = 10,
    parameter int ID_W        = $clog2(NUM_ICONS)
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic [9:0]        vert,
    input  wire logic [9:0]        horz,
    input  wire logic              frame_tick,
    icon_scheduler_if.slave        upd,
    output logic      [ADDR_W-1:0] rom_addr,
    input  wire logic [7:0]        rom_data,
    output logic      [7:0]        icon_out,
    output logic                   icon_hit,
    output logic      [ID_W-1:0]   icon_id
);

    import icon_pkg::*;

    state_t             state;
    icon_pos_t          sh  [NUM_ICONS];
    icon_pos_t          act [NUM_ICONS];

    logic [NUM_ICONS-1:0] hit;
    logic [ADDR_W-1:0]    ofs [NUM_ICONS];

    logic                 win_hit;
    logic [ID_W-1:0]      win_id;
    logic [ADDR_W-1:0]    win_ofs;
    logic [ADDR_W-1:0]    win_addr;

    logic                 hit_d1;
    logic [ID_W-1:0]      id_d1;
    logic                 accept;

    assign upd.upd_ready = reset_n && (state == ST_RUN);
    assign accept        = upd.upd_valid && upd.upd_ready;

    generate
        for (genvar i = 0; i < NUM_ICONS; i++) begin : g_hit
            icon_hit_test #(
                .ICON_WIDTH  (ICON_WIDTH),
                .ICON_HEIGHT (ICON_HEIGHT),
                .ADDR_W      (ADDR_W)
            ) u_hit (
                .pos  (act[i]),
                .vert (vert),
                .horz (horz),
                .hit  (hit[i]),
                .ofs  (ofs[i])
            );
        end
    endgenerate

    // Scan from the lowest priority upward so the lowest set index is left standing
    always_comb begin
        win_hit = 1'b0;
        win_id  = '0;
        win_ofs = '0;
        for (int i = NUM_ICONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_hit = 1'b1;
                win_id  = ID_W'(i);
                win_ofs = ofs[i];
            end
        end
    end

    assign win_addr = ADDR_W'(win_id) * ADDR_W'(ICON_SIZE) + win_ofs;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            for (int i = 0; i < NUM_ICONS; i++) begin
                sh[i]  <= '0;
                act[i] <= '0;
            end
            rom_addr <= ADDR_W'(BLANK);
            hit_d1   <= 1'b0;
            id_d1    <= '0;
            icon_hit <= 1'b0;
            icon_id  <= '0;
            icon_out <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (frame_tick) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_RUN;
                    act   <= sh;
                end
                default: state <= ST_RUN;
            endcase

            // Out-of-range IDs match no slot and fall away silently
            if (accept) begin
                for (int i = 0; i < NUM_ICONS; i++) begin
                    if (32'(upd.upd_id) == i) begin
                        sh[i] <= '{x: upd.upd_x, y: upd.upd_y, en: upd.upd_en};
                    end
                end
            end

            rom_addr <= win_hit ? win_addr : ADDR_W'(BLANK);
            hit_d1   <= win_hit;
            id_d1    <= win_id;
            icon_hit <= hit_d1;
            icon_id  <= id_d1;
            icon_out <= rom_data;
        end
    end

endmodule

`default_nettype wire
